register_access_scoreboard: RTL and testbench

Parametrised register-access stage that sits between decode and address generation. It holds an `NUM_REGS`-entry general register file with sized writeback. A per-register pending-write scoreboard stalls decode on read-after-write hazards. Source operands are delivered through a real one-deep valid/ready pipe register rather than a combinational bypass. Optional writeback-to-read forwarding shortens hazard stalls.

---
 rtl/register_access_scoreboard.sv | 159 +++++++++++++++
 tb/tb_register_access_scoreboard.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_access_scoreboard.sv
`default_nettype none
// =============================================================================
// register_access_scoreboard: register file, pending-write scoreboard and
// one-deep operand pipe. Optional macro RA_FORWARD_EN adds writeback forwarding.
// Revision: 1.0
// =============================================================================
module register_access_scoreboard #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 8,
  parameter int IDX_W     = 3,
  parameter int PEND_W    = 2,
  parameter int PAYLOAD_W = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 d_valid,
  output logic                 d_ready,
  input  logic [IDX_W-1:0]     d_src0,
  input  logic [IDX_W-1:0]     d_src1,
  input  logic                 d_src0_en,
  input  logic                 d_src1_en,
  input  logic [IDX_W-1:0]     d_dst,
  input  logic                 d_dst_en,
  input  logic [PAYLOAD_W-1:0] d_payload,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic [DATA_W-1:0]    r_src0_val,
  output logic [DATA_W-1:0]    r_src1_val,
  output logic [IDX_W-1:0]     r_dst,
  output logic                 r_dst_en,
  output logic [PAYLOAD_W-1:0] r_payload,
  input  logic [IDX_W-1:0]     wb_reg_number,
  input  logic                 wb_reg_en,
  input  logic [1:0]           wb_reg_size,
  input  logic [DATA_W-1:0]    wb_reg_data,
  output logic                 busy
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [DATA_W-1:0]   rf   [NUM_REGS];
  logic [PEND_W-1:0]   pend [NUM_REGS];

  logic [DATA_W-1:0]   src0_rd;
  logic [DATA_W-1:0]   src1_rd;
  logic                hz0;
  logic                hz1;
  logic                full;
  logic                stall;
  logic                accept;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] wbh_vec;
  logic [NUM_REGS-1:0] nz_vec;

  // Sized writeback: only the addressed low bytes change, upper bytes are kept.
  function automatic logic [DATA_W-1:0] wb_merge(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] data,
    input logic [1:0]        size
  );
    logic [DATA_W-1:0] res;
    res = old_val;
    case (size)
      2'd0:    res[7:0]  = data[7:0];
      2'd1:    res[15:0] = data[15:0];
      default: res       = data;
    endcase
    return res;
  endfunction

`ifdef RA_FORWARD_EN
  logic wb_hit0;
  logic wb_hit1;
  assign wb_hit0 = wb_reg_en & (wb_reg_number == d_src0);
  assign wb_hit1 = wb_reg_en & (wb_reg_number == d_src1);
  // The last outstanding writer landing this cycle releases the hazard.
  assign hz0 = d_src0_en & (pend[d_src0] != '0) & ~(wb_hit0 & (pend[d_src0] == PEND_ONE));
  assign hz1 = d_src1_en & (pend[d_src1] != '0) & ~(wb_hit1 & (pend[d_src1] == PEND_ONE));
  assign src0_rd = wb_hit0 ? wb_merge(rf[d_src0], wb_reg_data, wb_reg_size) : rf[d_src0];
  assign src1_rd = wb_hit1 ? wb_merge(rf[d_src1], wb_reg_data, wb_reg_size) : rf[d_src1];
`else
  assign hz0 = d_src0_en & (pend[d_src0] != '0);
  assign hz1 = d_src1_en & (pend[d_src1] != '0);
  assign src0_rd = rf[d_src0];
  assign src1_rd = rf[d_src1];
`endif

  // A saturated counter still admits a writer when one of its writers retires now.
  assign full    = d_dst_en & (pend[d_dst] == PEND_MAX)
                 & ~(wb_reg_en & (wb_reg_number == d_dst));
  assign stall   = hz0 | hz1 | full;
  assign d_ready = ~stall & (~r_valid | r_ready);
  assign accept  = d_valid & d_ready & ~flush & ~reset;

  always_comb begin
    inc_vec = '0;
    wbh_vec = '0;
    nz_vec  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      inc_vec[i] = accept & d_dst_en & (d_dst == IDX_W'(i));
      wbh_vec[i] = wb_reg_en & (wb_reg_number == IDX_W'(i));
      nz_vec[i]  = (pend[i] != '0);
    end
  end

  assign busy = |nz_vec;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf[i] <= '0;
      end
    end else if (wb_reg_en) begin
      rf[wb_reg_number] <= wb_merge(rf[wb_reg_number], wb_reg_data, wb_reg_size);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        pend[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (inc_vec[i] && !wbh_vec[i]) begin
          pend[i] <= pend[i] + PEND_ONE;
        end else if (wbh_vec[i] && !inc_vec[i] && (pend[i] != '0)) begin
          pend[i] <= pend[i] - PEND_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_src0_val <= '0;
      r_src1_val <= '0;
      r_dst      <= '0;
      r_dst_en   <= 1'b0;
      r_payload  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (accept) begin
      r_valid    <= 1'b1;
      r_src0_val <= d_src0_en ? src0_rd : '0;
      r_src1_val <= d_src1_en ? src1_rd : '0;
      r_dst      <= d_dst;
      r_dst_en   <= d_dst_en;
      r_payload  <= d_payload;
    end else if (r_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_register_access_scoreboard.sv
`default_nettype none
// Bench for register_access_scoreboard: directed scenarios plus random traffic
// compared against an array-based model of the register/scoreboard rules.
module tb_register_access_scoreboard;
  localparam int DATA_W    = 32;
  localparam int NUM_REGS  = 8;
  localparam int IDX_W     = 3;
  localparam int PEND_W    = 2;
  localparam int PAYLOAD_W = 64;
  localparam int PEND_MAX  = (1 << PEND_W) - 1;
`ifdef RA_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset, flush, d_valid, d_ready;
  logic [IDX_W-1:0]     d_src0, d_src1, d_dst;
  logic                 d_src0_en, d_src1_en, d_dst_en;
  logic [PAYLOAD_W-1:0] d_payload;
  logic                 r_valid, r_ready;
  logic [DATA_W-1:0]    r_src0_val, r_src1_val;
  logic [IDX_W-1:0]     r_dst;
  logic                 r_dst_en;
  logic [PAYLOAD_W-1:0] r_payload;
  logic [IDX_W-1:0]     wb_reg_number;
  logic                 wb_reg_en;
  logic [1:0]           wb_reg_size;
  logic [DATA_W-1:0]    wb_reg_data;
  logic                 busy;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0]    m_rf   [NUM_REGS];
  int                   m_pend [NUM_REGS];
  bit                   m_rv;
  logic [DATA_W-1:0]    m_s0, m_s1;
  logic [IDX_W-1:0]     m_dst;
  logic                 m_dst_en;
  logic [PAYLOAD_W-1:0] m_pay;

  register_access_scoreboard #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W),
    .PEND_W(PEND_W), .PAYLOAD_W(PAYLOAD_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .d_valid(d_valid), .d_ready(d_ready),
    .d_src0(d_src0), .d_src1(d_src1), .d_src0_en(d_src0_en), .d_src1_en(d_src1_en),
    .d_dst(d_dst), .d_dst_en(d_dst_en), .d_payload(d_payload),
    .r_valid(r_valid), .r_ready(r_ready),
    .r_src0_val(r_src0_val), .r_src1_val(r_src1_val),
    .r_dst(r_dst), .r_dst_en(r_dst_en), .r_payload(r_payload),
    .wb_reg_number(wb_reg_number), .wb_reg_en(wb_reg_en),
    .wb_reg_size(wb_reg_size), .wb_reg_data(wb_reg_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] data,
                                        input logic [1:0] size);
    logic [31:0] mask;
    mask = (size == 2'd0) ? 32'h0000_00FF : (size == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    return (old_val & ~mask) | (data & mask);
  endfunction

  function automatic bit wb_targets(input int idx);
    return wb_reg_en && (int'(wb_reg_number) == idx);
  endfunction

  function automatic bit m_hazard(input int idx, input bit en);
    if (!en || m_pend[idx] == 0) return 1'b0;
    if (FWD && m_pend[idx] == 1 && wb_targets(idx)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_ready();
    bit full;
    full = d_dst_en && (m_pend[d_dst] == PEND_MAX) && !wb_targets(int'(d_dst));
    return !(m_hazard(int'(d_src0), d_src0_en) || m_hazard(int'(d_src1), d_src1_en) || full)
           && (!m_rv || r_ready);
  endfunction

  function automatic logic [31:0] m_read(input int idx, input bit en);
    if (!en) return 32'h0;
    if (FWD && wb_targets(idx)) return merge(m_rf[idx], wb_reg_data, wb_reg_size);
    return m_rf[idx];
  endfunction

  function automatic bit m_busy();
    for (int i = 0; i < NUM_REGS; i++) if (m_pend[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    reset = 1'b0; flush = 1'b0; d_valid = 1'b0;
    d_src0 = '0; d_src1 = '0; d_src0_en = 1'b0; d_src1_en = 1'b0;
    d_dst = '0; d_dst_en = 1'b0; d_payload = '0; r_ready = 1'b1;
    wb_reg_number = '0; wb_reg_en = 1'b0; wb_reg_size = 2'd0; wb_reg_data = '0;
  endtask

  // Advance one clock and move the model to the state the rules dictate.
  task automatic tick();
    bit acc;
    logic [31:0] v0, v1;
    acc = d_valid && m_ready() && !flush && !reset;
    v0  = m_read(int'(d_src0), d_src0_en);
    v1  = m_read(int'(d_src1), d_src1_en);
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin m_rf[i] = '0; m_pend[i] = 0; end
      m_rv = 0; m_s0 = '0; m_s1 = '0; m_dst = '0; m_dst_en = 1'b0; m_pay = '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        bit inc, hit;
        inc = acc && d_dst_en && (int'(d_dst) == i);
        hit = wb_targets(i);
        if (flush) m_pend[i] = 0;
        else if (inc && !hit) m_pend[i] = m_pend[i] + 1;
        else if (hit && !inc && m_pend[i] > 0) m_pend[i] = m_pend[i] - 1;
      end
      if (wb_reg_en) m_rf[wb_reg_number] = merge(m_rf[wb_reg_number], wb_reg_data, wb_reg_size);
      if (flush) m_rv = 0;
      else if (acc) begin
        m_rv = 1; m_s0 = v0; m_s1 = v1; m_dst = d_dst; m_dst_en = d_dst_en; m_pay = d_payload;
      end else if (r_ready) m_rv = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    wb_reg_en = 1'b1; wb_reg_number = 3'd5; wb_reg_size = 2'd3; wb_reg_data = 32'hDEAD_BEEF;
    tick();
    tick();
    idle();
    #1;
    checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL reset_d_ready: got %b want 1", d_ready); end
    checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL reset_r_valid: got %b want 0", r_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if ({r_src0_val, r_src1_val, r_dst, r_dst_en, r_payload} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h/%h/%h/%b/%h want all 0",
                         r_src0_val, r_src1_val, r_dst, r_dst_en, r_payload);
    end
  endtask

  task automatic test_write_read();
    idle();
    wb_reg_en = 1'b1; wb_reg_number = 3'd3; wb_reg_size = 2'd2; wb_reg_data = 32'h1234_5678;
    tick();
    idle();
    d_valid = 1'b1; d_src0 = 3'd3; d_src0_en = 1'b1; d_payload = 64'h0123_4567_89AB_CDEF;
    #1;
    checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL read_r3_ready: got %b want 1", d_ready); end
    tick();
    idle();
    checks++; if (r_valid !== 1'b1) begin errors++; $display("FAIL read_r3_valid: got %b want 1", r_valid); end
    checks++; if (r_src0_val !== 32'h1234_5678) begin errors++; $display("FAIL read_r3_val: got %h want 12345678", r_src0_val); end
    checks++; if (r_src1_val !== 32'h0) begin errors++; $display("FAIL read_disabled_src: got %h want 0", r_src1_val); end
    checks++; if (r_payload !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL read_payload: got %h", r_payload); end
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i != 3) begin
        d_valid = 1'b1; d_src0 = IDX_W'(i); d_src1 = IDX_W'(i); d_src0_en = 1'b1; d_src1_en = 1'b1;
        tick();
        checks++;
        if (r_valid !== 1'b1 || r_src0_val !== 32'h0 || r_src1_val !== 32'h0) begin
          errors++; $display("FAIL read_zero_r%0d: got v=%b %h %h want 1 0 0", i, r_valid, r_src0_val, r_src1_val);
        end
      end
    end
    idle();
  endtask

  task automatic test_sized_writeback();
    idle();
    wb_reg_en = 1'b1; wb_reg_number = 3'd1; wb_reg_size = 2'd3; wb_reg_data = 32'hAABB_CCDD;
    tick();
    wb_reg_size = 2'd0; wb_reg_data = 32'hFFFF_FF11;
    tick();
    idle();
    d_valid = 1'b1; d_src1 = 3'd1; d_src1_en = 1'b1;
    tick();
    idle();
    checks++; if (r_src1_val !== 32'hAABB_CC11) begin errors++; $display("FAIL byte_wb: got %h want aabbcc11", r_src1_val); end
    wb_reg_en = 1'b1; wb_reg_number = 3'd1; wb_reg_size = 2'd1; wb_reg_data = 32'h9999_2233;
    tick();
    idle();
    d_valid = 1'b1; d_src0 = 3'd1; d_src0_en = 1'b1;
    tick();
    idle();
    checks++; if (r_src0_val !== 32'hAABB_2233) begin errors++; $display("FAIL word_wb: got %h want aabb2233", r_src0_val); end
  endtask

  task automatic test_hazard();
    idle();
    d_valid = 1'b1; d_dst = 3'd2; d_dst_en = 1'b1;
    tick();
    idle();
    d_valid = 1'b1; d_src0 = 3'd2; d_src0_en = 1'b1;
    #1;
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL raw_stall: got %b want 0", d_ready); end
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL raw_busy: got %b want 1", busy); end
    wb_reg_en = 1'b1; wb_reg_number = 3'd2; wb_reg_size = 2'd2; wb_reg_data = 32'd5;
    #1;
`ifdef RA_FORWARD_EN
    checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL fwd_release: got %b want 1", d_ready); end
    tick();
`else
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL nofwd_wb_cycle: got %b want 0", d_ready); end
    tick();
    wb_reg_en = 1'b0;
    #1;
    checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL nofwd_release: got %b want 1", d_ready); end
    tick();
`endif
    idle();
    checks++;
    if (r_valid !== 1'b1 || r_src0_val !== 32'd5) begin
      errors++; $display("FAIL raw_value: got v=%b %h want 1 5", r_valid, r_src0_val);
    end
  endtask

  task automatic test_full();
    idle();
    d_valid = 1'b1; d_dst = 3'd4; d_dst_en = 1'b1;
    for (int k = 0; k < PEND_MAX; k++) begin
      #1;
      checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL writer%0d_ready: got %b want 1", k, d_ready); end
      tick();
    end
    #1;
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL full_stall: got %b want 0", d_ready); end
    wb_reg_en = 1'b1; wb_reg_number = 3'd4; wb_reg_size = 2'd2; wb_reg_data = 32'h44;
    #1;
    checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL full_wb_issue: got %b want 1", d_ready); end
    tick();
    wb_reg_en = 1'b0;
    #1;
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL full_count_kept: got %b want 0", d_ready); end
    idle();
    wb_reg_en = 1'b1; wb_reg_number = 3'd4; wb_reg_size = 2'd2;
    for (int k = 0; k < PEND_MAX; k++) tick();
    idle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_drain_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [PAYLOAD_W-1:0] pa;
    idle();
    pa = {$urandom, $urandom};
    d_valid = 1'b1; d_payload = pa;
    tick();
    r_ready = 1'b0; d_payload = ~pa;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL hold%0d_ready: got %b want 0", k, d_ready); end
      tick();
      checks++;
      if (r_valid !== 1'b1 || r_payload !== pa) begin
        errors++; $display("FAIL hold%0d_stable: got v=%b %h want 1 %h", k, r_valid, r_payload, pa);
      end
    end
    r_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_ready: got %b want 1", k, d_ready); end
      tick();
      checks++;
      if (r_valid !== 1'b1 || r_payload !== d_payload) begin
        errors++; $display("FAIL b2b%0d_xfer: got v=%b %h want 1 %h", k, r_valid, r_payload, d_payload);
      end
      d_payload = d_payload + 64'd1;
    end
    idle();
  endtask

  task automatic test_flush();
    idle();
    d_valid = 1'b1; d_dst = 3'd6; d_dst_en = 1'b1;
    tick();
    flush = 1'b1;
    wb_reg_en = 1'b1; wb_reg_number = 3'd0; wb_reg_size = 2'd2; wb_reg_data = 32'd7;
    tick();
    idle();
    checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL flush_r_valid: got %b want 0", r_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
    d_valid = 1'b1; d_src0 = 3'd6; d_src0_en = 1'b1; d_src1 = 3'd0; d_src1_en = 1'b1;
    #1;
    checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL flush_reader_ready: got %b want 1", d_ready); end
    tick();
    idle();
    checks++;
    if (r_valid !== 1'b1 || r_src1_val !== 32'd7 || r_src0_val !== 32'd0) begin
      errors++; $display("FAIL flush_reads: got v=%b r6=%h r0=%h want 1 0 7", r_valid, r_src0_val, r_src1_val);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      int widx;
      idle();
      d_valid   = ($urandom_range(0, 3) != 0);
      d_src0    = IDX_W'($urandom_range(0, NUM_REGS - 1));
      d_src1    = IDX_W'($urandom_range(0, NUM_REGS - 1));
      d_src0_en = $urandom_range(0, 1);
      d_src1_en = $urandom_range(0, 1);
      d_dst     = IDX_W'($urandom_range(0, NUM_REGS - 1));
      d_dst_en  = $urandom_range(0, 1);
      d_payload = {$urandom, $urandom};
      r_ready   = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      widx      = $urandom_range(0, NUM_REGS - 1);
      wb_reg_en     = ($urandom_range(0, 3) == 0) || (m_pend[widx] > 0 && $urandom_range(0, 1) == 1);
      wb_reg_number = IDX_W'(widx);
      wb_reg_size   = 2'($urandom_range(0, 3));
      wb_reg_data   = $urandom;
      #1;
      checks++; if (d_ready !== m_ready()) begin errors++; $display("FAIL rnd%0d_d_ready: got %b want %b", c, d_ready, m_ready()); end
      tick();
      checks++; if (r_valid !== m_rv) begin errors++; $display("FAIL rnd%0d_r_valid: got %b want %b", c, r_valid, m_rv); end
      if (m_rv) begin
        checks++;
        if ({r_src0_val, r_src1_val, r_dst, r_dst_en, r_payload} !== {m_s0, m_s1, m_dst, m_dst_en, m_pay}) begin
          errors++; $display("FAIL rnd%0d_pipe: got %h %h %h %b %h want %h %h %h %b %h", c,
                             r_src0_val, r_src1_val, r_dst, r_dst_en, r_payload,
                             m_s0, m_s1, m_dst, m_dst_en, m_pay);
        end
      end
      checks++; if (busy !== m_busy()) begin errors++; $display("FAIL rnd%0d_busy: got %b want %b", c, busy, m_busy()); end
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation bound expired");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    m_rv = 0;
    for (int i = 0; i < NUM_REGS; i++) begin m_rf[i] = '0; m_pend[i] = 0; end
    test_reset();
    test_write_read();
    test_sized_writeback();
    test_hazard();
    test_full();
    test_back_to_back();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
